mod_bcd_cnt: RTL and testbench
==============================

MOD_BCD_CNT -- requirements
Module: mod_bcd_cnt

Interface
REQ-001 SHALL have parameter MODULUS, default 60: count modulus; legal range 2..(10*2**QHW); count runs 0..MODULUS-1.
REQ-002 SHALL have parameter QHW, default 3: tens-digit width in bits.
REQ-003 SHALL have port CLK  input  1: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_N  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port CLR  input  1: synchronous clear to 0.
REQ-006 SHALL have port EN  input  1: count enable, one step per cycle.
REQ-007 SHALL have port LD  input  1: synchronous load of DH:DL.
REQ-008 SHALL have port DH  input  QHW: BCD tens digit to load.
REQ-009 SHALL have port DL  input  4: BCD ones digit to load.
REQ-010 SHALL have port DN  input  1: count direction, 1 = down; present only with MOD_BCD_CNT_DOWN_EN.
REQ-011 SHALL have port QH  output  QHW: registered tens digit.
REQ-012 SHALL have port QL  output  4: registered ones digit.
REQ-013 SHALL have port CA  output  1: combinational carry/borrow, for cascading into the next stage's EN.
REQ-014 SHALL have port LDERR  output  1: registered one-cycle flag for a rejected load.

Function
REQ-015 SHALL define terminal value T = MODULUS-1, with TH = T/10 and TL = T%10.
REQ-016 SHALL apply this per-cycle priority: RST_N low, then CLR, then LD, then EN, else hold.
REQ-017 SHALL, on an up step, set QL to 0 and increment QH when QL==9; otherwise increment QL.
REQ-018 SHALL, on an up step at QH==TH and QL==TL, wrap to QH=0, QL=0 in one cycle.
REQ-019 SHALL assert CA when EN=1, CLR=0, LD=0, direction is up, and QH:QL==TH:TL.
REQ-020 SHALL, on LD with DL<=9 and 10*DH+DL<=T, load QH=DH, QL=DL; EN is ignored that cycle.
REQ-021 SHALL, on LD with an illegal value, hold QH:QL unchanged and set LDERR=1 for the next cycle only.
REQ-022 SHALL hold LDERR=0 in every other cycle, including when CLR and LD are both high (CLR wins, no check is made).
REQ-023 SHALL never present an output value outside the BCD sequence 0..T.
REQ-024 SHALL, with MODULUS<=10, hold QH at 0 and let QL wrap from T to 0.

Reset
REQ-025 SHALL, when RST_N=0 at a rising CLK, set QH=0, QL=0 and LDERR=0, regardless of CLR, LD or EN.
REQ-026 SHALL force CA=0 while RST_N=0.
REQ-027 SHALL, with reset asserted mid-count, discard the in-flight step; counting resumes from 0 on the first enabled cycle after RST_N returns high.

Configuration
REQ-028 SHALL, with macro MOD_BCD_CNT_DOWN_EN defined, provide the DN port and down counting.
REQ-029 SHALL, on a down step, set QL=9 and decrement QH when QL==0.
REQ-030 SHALL, on a down step at 0:0, wrap to TH:TL.
REQ-031 SHALL, when counting down, assert CA as a borrow when EN=1, CLR=0, LD=0 and QH:QL==0:0.
REQ-032 SHALL, when DN changes, take effect on that same cycle's step.
REQ-033 SHALL, without MOD_BCD_CNT_DOWN_EN, omit the DN port and count up only, with behaviour identical to DN=0.

Verification
REQ-034 SHALL cover: MODULUS=60, EN=1 for 60 cycles from 0 -> sequence 00..59 then 00; CA high only in the 59 cycle.
REQ-035 SHALL cover: MODULUS=24, LD with DH=2, DL=3, then EN=1 -> QH:QL=23 with CA=1; next cycle 00.
REQ-036 SHALL cover: MODULUS=24, LD with DH=2, DL=5 while count is 07 -> count stays 07; LDERR=1 for exactly one cycle.
REQ-037 SHALL cover: CLR=1, LD=1, EN=1 together at count 15 -> 00; LDERR=0; CA=0.
REQ-038 SHALL cover: RST_N=0 for one cycle at count 42 with EN=1 -> 00 next cycle; on release, 01 after one enabled cycle.
REQ-039 SHALL cover: with MOD_BCD_CNT_DOWN_EN and MODULUS=60, DN=1, EN=1 from 01 -> 00 (CA=1 in that 00 cycle), then 59, then 58.

Source files
------------

// File: rtl/mod_bcd_cnt.sv
// Modulo-MODULUS two-digit BCD counter with load, clear, carry output and load-error flag.
// Define MOD_BCD_CNT_DOWN_EN to add the DN port and down counting with borrow on CA.
module mod_bcd_cnt #(
  parameter int MODULUS = 60,
  parameter int QHW     = 3
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CLR,
  input  logic           EN,
  input  logic           LD,
`ifdef MOD_BCD_CNT_DOWN_EN
  input  logic           DN,
`endif
  input  logic [QHW-1:0] DH,
  input  logic [3:0]     DL,
  output logic [QHW-1:0] QH,
  output logic [3:0]     QL,
  output logic           CA,
  output logic           LDERR
);

  localparam int             T      = MODULUS - 1;
  localparam logic [QHW-1:0] TH     = QHW'(T / 10);
  localparam logic [3:0]     TL     = 4'(T % 10);
  localparam logic [QHW-1:0] QH_ONE = QHW'(1'b1);
  localparam logic [QHW-1:0] QH_ZRO = QHW'(1'b0);

  // True when h:l is a legal BCD value within 0..T.
  function automatic logic bcd_in_range(input logic [QHW-1:0] h, input logic [3:0] l);
    return (l <= 4'd9) && ((h < TH) || ((h == TH) && (l <= TL)));
  endfunction

  logic [QHW-1:0] q_h_r, q_h_nxt_s;
  logic [3:0]     q_l_r, q_l_nxt_s;
  logic           lderr_r, lderr_nxt_s;
  logic           dn_s, at_top_s, at_zero_s, ld_ok_s, state_ok_s, ca_s;

`ifdef MOD_BCD_CNT_DOWN_EN
  assign dn_s = DN;
`else
  assign dn_s = 1'b0;
`endif

  assign at_top_s   = (q_h_r == TH) && (q_l_r == TL);
  assign at_zero_s  = (q_h_r == QH_ZRO) && (q_l_r == 4'd0);
  assign ld_ok_s    = bcd_in_range(DH, DL);
  assign state_ok_s = bcd_in_range(q_h_r, q_l_r);

  // Next-state selection: CLR, then LD, then EN; an out-of-range state recovers to zero.
  always_comb begin
    q_h_nxt_s   = q_h_r;
    q_l_nxt_s   = q_l_r;
    lderr_nxt_s = 1'b0;
    if (CLR) begin
      q_h_nxt_s = QH_ZRO;
      q_l_nxt_s = 4'd0;
    end else if (LD) begin
      if (ld_ok_s) begin
        q_h_nxt_s = DH;
        q_l_nxt_s = DL;
      end else begin
        lderr_nxt_s = 1'b1;
      end
    end else if (!state_ok_s) begin
      q_h_nxt_s = QH_ZRO;
      q_l_nxt_s = 4'd0;
    end else if (EN) begin
      if (dn_s) begin
        if (at_zero_s) begin
          q_h_nxt_s = TH;
          q_l_nxt_s = TL;
        end else if (q_l_r == 4'd0) begin
          q_h_nxt_s = q_h_r - QH_ONE;
          q_l_nxt_s = 4'd9;
        end else begin
          q_l_nxt_s = q_l_r - 4'd1;
        end
      end else begin
        if (at_top_s) begin
          q_h_nxt_s = QH_ZRO;
          q_l_nxt_s = 4'd0;
        end else if (q_l_r == 4'd9) begin
          q_h_nxt_s = q_h_r + QH_ONE;
          q_l_nxt_s = 4'd0;
        end else begin
          q_l_nxt_s = q_l_r + 4'd1;
        end
      end
    end else begin
      q_h_nxt_s = q_h_r;
      q_l_nxt_s = q_l_r;
    end
  end

  // Carry/borrow for cascading: only on a plain enabled step at the wrap point.
  always_comb begin
    ca_s = 1'b0;
    if (RST_N && EN && !CLR && !LD) begin
      ca_s = dn_s ? at_zero_s : at_top_s;
    end else begin
      ca_s = 1'b0;
    end
  end

  // Count and load-error registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_h_r   <= QH_ZRO;
      q_l_r   <= 4'd0;
      lderr_r <= 1'b0;
    end else begin
      q_h_r   <= q_h_nxt_s;
      q_l_r   <= q_l_nxt_s;
      lderr_r <= lderr_nxt_s;
    end
  end

  assign QH    = q_h_r;
  assign QL    = q_l_r;
  assign LDERR = lderr_r;
  assign CA    = ca_s;

endmodule

// File: tb/tb_mod_bcd_cnt.sv
// Directed self-checking bench for mod_bcd_cnt (instances with MODULUS 60, 24 and 5).
module tb_mod_bcd_cnt;

  logic       clk;
  logic       rst_n, clr, en, ld, dn;
  logic [2:0] dh;
  logic [3:0] dl;
  logic [2:0] qh60, qh24, qh5;
  logic [3:0] ql60, ql24, ql5;
  logic       ca60, ca24, ca5;
  logic       lderr60, lderr24, lderr5;
  int         errors;
  int         checks;

  mod_bcd_cnt #(.MODULUS(60), .QHW(3)) dut60 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .LD(ld),
`ifdef MOD_BCD_CNT_DOWN_EN
    .DN(dn),
`endif
    .DH(dh), .DL(dl), .QH(qh60), .QL(ql60), .CA(ca60), .LDERR(lderr60));

  mod_bcd_cnt #(.MODULUS(24), .QHW(3)) dut24 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .LD(ld),
`ifdef MOD_BCD_CNT_DOWN_EN
    .DN(dn),
`endif
    .DH(dh), .DL(dl), .QH(qh24), .QL(ql24), .CA(ca24), .LDERR(lderr24));

  mod_bcd_cnt #(.MODULUS(5), .QHW(3)) dut5 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .EN(en), .LD(ld),
`ifdef MOD_BCD_CNT_DOWN_EN
    .DN(dn),
`endif
    .DH(dh), .DL(dl), .QH(qh5), .QL(ql5), .CA(ca5), .LDERR(lderr5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int val(input logic [2:0] h, input logic [3:0] l);
    return 10 * int'(h) + int'(l);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; ld = 1'b0; dn = 1'b0;
    dh = 3'd0; dl = 4'd0;
    tick();
    chk("rst_cnt", val(qh60, ql60), 0);
    chk("rst_lderr", int'(lderr60), 0);
    chk("rst_ca", int'(ca60), 0);

    // Full up-count wrap at MODULUS 60 and 5
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      chk("seq60", val(qh60, ql60), i);
      chk("ca60", int'(ca60), (i == 59) ? 1 : 0);
      chk("seq5", val(qh5, ql5), i % 5);
      chk("ca5", int'(ca5), ((i % 5) == 4) ? 1 : 0);
      tick();
    end
    chk("wrap60", val(qh60, ql60), 0);
    chk("wrap5", val(qh5, ql5), 0);

    // Load terminal 23 with EN high, then wrap
    ld = 1'b1; dh = 3'd2; dl = 4'd3; en = 1'b1;
    tick();
    chk("ld23", val(qh24, ql24), 23);
    chk("ld23_lderr", int'(lderr24), 0);
    ld = 1'b0; en = 1'b1;
    #1;
    chk("ca24_top", int'(ca24), 1);
    tick();
    chk("wrap24", val(qh24, ql24), 0);

    // Rejected loads leave the count alone and flag one cycle
    ld = 1'b1; dh = 3'd0; dl = 4'd7; en = 1'b0;
    tick();
    chk("ld07", val(qh24, ql24), 7);
    dh = 3'd2; dl = 4'd5;
    #1;
    chk("ca24_ld", int'(ca24), 0);
    tick();
    chk("bad25_hold", val(qh24, ql24), 7);
    chk("bad25_lderr", int'(lderr24), 1);
    chk("ok25_mod60", val(qh60, ql60), 25);
    chk("ok25_lderr60", int'(lderr60), 0);
    ld = 1'b0;
    tick();
    chk("lderr_1cyc", int'(lderr24), 0);
    chk("hold07", val(qh24, ql24), 7);
    ld = 1'b1; dh = 3'd0; dl = 4'd10;
    tick();
    chk("baddl_hold", val(qh24, ql24), 7);
    chk("baddl_lderr", int'(lderr24), 1);
    chk("baddl_lderr60", int'(lderr60), 1);
    ld = 1'b0;
    tick();

    // CLR beats LD and EN, no load check
    ld = 1'b1; dh = 3'd1; dl = 4'd5;
    tick();
    chk("ld15", val(qh24, ql24), 15);
    clr = 1'b1; ld = 1'b1; en = 1'b1; dh = 3'd2; dl = 4'd5;
    #1;
    chk("clr_ca", int'(ca24), 0);
    tick();
    chk("clr_cnt", val(qh24, ql24), 0);
    chk("clr_lderr", int'(lderr24), 0);
    clr = 1'b0; ld = 1'b0;

    // Reset mid-count discards the step
    ld = 1'b1; dh = 3'd4; dl = 4'd2; en = 1'b0;
    tick();
    chk("ld42", val(qh60, ql60), 42);
    ld = 1'b0; en = 1'b1; rst_n = 1'b0;
    tick();
    chk("rst42_cnt", val(qh60, ql60), 0);
    chk("rst42_lderr", int'(lderr60), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst", val(qh60, ql60), 1);
    en = 1'b0;
    tick();
    chk("hold01", val(qh60, ql60), 1);

    // CA forced low during reset even at the terminal value
    ld = 1'b1; dh = 3'd5; dl = 4'd9;
    tick();
    ld = 1'b0; en = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_ca59", int'(ca60), 0);
    tick();
    chk("rst59_cnt", val(qh60, ql60), 0);
    rst_n = 1'b1;

`ifdef MOD_BCD_CNT_DOWN_EN
    // Down count with borrow
    ld = 1'b1; dh = 3'd0; dl = 4'd1; en = 1'b1; dn = 1'b1;
    tick();
    chk("dn_ld01", val(qh60, ql60), 1);
    ld = 1'b0;
    #1;
    chk("dn_ca01", int'(ca60), 0);
    tick();
    chk("dn_00", val(qh60, ql60), 0);
    chk("dn_ca00", int'(ca60), 1);
    tick();
    chk("dn_59", val(qh60, ql60), 59);
    chk("dn_23", val(qh24, ql24), 23);
    chk("dn_ca59", int'(ca60), 0);
    tick();
    chk("dn_58", val(qh60, ql60), 58);
    dn = 1'b0; en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
